seq_glide: RTL and testbench

Glide (portamento) stage placed directly downstream of the step sequencer. It consumes the sequencer's stepped signed control value and slews its output toward each new step at a programmable rate, so downstream oscillators and filters see ramps instead of jumps. It also emits a one-cycle trigger on every step change for envelope generators.

---
 rtl/seq_glide.sv | 110 +++++++++++
 tb/tb_seq_glide.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_glide.sv
// Portamento stage: slews a stepped signed control value toward each new step.
// Optional `SEQ_GLIDE_TRIG_EN adds a one-cycle trig output on every target change.
`ifndef BITS
`define BITS 12
`endif

module seq_glide #(
    parameter int unsigned RATE_DIV = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [`BITS-1:0] sigIn,
    input  logic [7:0]              slew,
    output logic signed [`BITS-1:0] sigOut,
`ifdef SEQ_GLIDE_TRIG_EN
    output logic                    trig,
`endif
    output logic                    busy
);

    localparam int W = `BITS;
    localparam int unsigned CntW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(RATE_DIV - 1);

    typedef enum logic [1:0] {StIdle, StRise, StFall} state_e;

    state_e                 state_q, state_d;
    logic signed [W-1:0]    target_q, target_d;
    logic signed [W-1:0]    sig_q, sig_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   tick;

    logic signed [W:0]      diff, mag, slew_ext, step_sum;

    assign target_d = sigIn;
    assign tick     = (cnt_q == CntMax);
    assign cnt_d    = tick ? '0 : cnt_q + 1'b1;

    // One extra bit keeps the full-scale distance and the stepped sum from wrapping.
    always_comb begin
        diff     = {target_q[W-1], target_q} - {sig_q[W-1], sig_q};
        mag      = diff[W] ? -diff : diff;
        slew_ext = $signed((W + 1)'(slew));
        step_sum = diff[W] ? ({sig_q[W-1], sig_q} - slew_ext)
                           : ({sig_q[W-1], sig_q} + slew_ext);
        sig_d    = sig_q;
        if (slew == 8'd0) begin
            sig_d = target_q;
        end else if (tick) begin
            if (mag <= slew_ext) begin
                sig_d = target_q;
            end else begin
                sig_d = step_sum[W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target_q <= '0;
            sig_q    <= '0;
            cnt_q    <= '0;
        end else begin
            target_q <= target_d;
            sig_q    <= sig_d;
            cnt_q    <= cnt_d;
        end
    end

    // State reflects the post-update values, so busy drops on the snap edge itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StIdle;
        if (target_d > sig_d) begin
            state_d = StRise;
        end else if (target_d < sig_d) begin
            state_d = StFall;
        end
    end

    always_comb begin
        busy = (state_q != StIdle);
    end

    assign sigOut = sig_q;

`ifdef SEQ_GLIDE_TRIG_EN
    logic trig_q, trig_d;

    assign trig_d = (sigIn != target_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= trig_d;
        end
    end

    assign trig = trig_q;
`endif

endmodule

// File: tb/tb_seq_glide.sv
// Scoreboard bench for seq_glide: expected sigOut changes are queued by the
// stimulus and popped by a negedge monitor whenever sigOut moves.
`ifndef BITS
`define BITS 12
`endif

module tb_seq_glide;

    localparam int unsigned RateDiv = 4;
    localparam int W = `BITS;

    typedef struct {
        logic signed [W-1:0] val;
        int                  gap;
        logic                busy;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic signed [W-1:0] sig_in;
    logic [7:0]          slew;
    logic signed [W-1:0] sig_out;
    logic                busy;
`ifdef SEQ_GLIDE_TRIG_EN
    logic                trig;
    int                  trig_cnt = 0;
`endif

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sb[$];
    logic mon_en = 1'b0;
    logic signed [W-1:0] prev = '0;
    int   last_cyc = 0;
    int   t0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    seq_glide #(
        .RATE_DIV(RateDiv)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sigIn (sig_in),
        .slew  (slew),
        .sigOut(sig_out),
`ifdef SEQ_GLIDE_TRIG_EN
        .trig  (trig),
`endif
        .busy  (busy)
    );

    // Monitor: every movement of sigOut must match the head of the scoreboard.
    always @(negedge clk) begin : mon
        exp_t e;
        if (mon_en) begin
`ifdef SEQ_GLIDE_TRIG_EN
            if (trig === 1'b1) trig_cnt++;
`endif
            if (sig_out !== prev) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change got=%0d required=none", sig_out);
                end else begin
                    e = sb.pop_front();
                    if (sig_out !== e.val || busy !== e.busy ||
                        (e.gap != 0 && (cyc - last_cyc) != e.gap)) begin
                        bad++;
                        $display("FAIL step got=%0d/busy=%0b/gap=%0d required=%0d/busy=%0b/gap=%0d",
                                 sig_out, busy, cyc - last_cyc, e.val, e.busy, e.gap);
                    end
                end
                last_cyc = cyc;
                prev     = sig_out;
            end
        end
    end

    task automatic push(input int v, input int gap, input logic b);
        exp_t e;
        e.val  = W'(v);
        e.gap  = gap;
        e.busy = b;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s got=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int bound);
        int n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < bound) begin
            tick_edge();
            n++;
        end
        check({name, "_left"}, sb.size(), 0);
        check({name, "_busy"}, int'(busy), 0);
    endtask

    task automatic wait_val(input int v, input int bound);
        int n = 0;
        while (sig_out !== W'(v) && n < bound) begin
            tick_edge();
            n++;
        end
        check("reach_value", int'(sig_out), v);
    endtask

    // Bypass jump: lands two edges after the change.
    task automatic jump(input int v);
        slew   = 8'd0;
        sig_in = W'(v);
        push(v, 0, 1'b0);
        drain("jump", 20);
    endtask

    // Ramp from current idle value "from" to "to" with step s.
    task automatic ramp_exp(input int from, input int to, input int s);
        int cur = from;
        int k   = 0;
        while (cur != to) begin
            if ((to - cur) <= s && (cur - to) <= s) cur = to;
            else if (to > cur) cur = cur + s;
            else cur = cur - s;
            push(cur, (k == 0) ? 0 : int'(RateDiv), (cur != to));
            k++;
        end
    endtask

    initial begin
        rst    = 1'b1;
        sig_in = '0;
        slew   = 8'd0;
        repeat (2) tick_edge();
        check("rst_sigout", int'(sig_out), 0);
        check("rst_busy", int'(busy), 0);
`ifdef SEQ_GLIDE_TRIG_EN
        check("rst_trig", int'(trig), 0);
`endif
        rst    = 1'b0;
        mon_en = 1'b1;
        tick_edge();

        // Slew 10, 0 -> 100.
`ifdef SEQ_GLIDE_TRIG_EN
        t0 = trig_cnt;
`endif
        slew   = 8'd10;
        sig_in = 12'sd100;
        ramp_exp(0, 100, 10);
        drain("ramp10", 100);
`ifdef SEQ_GLIDE_TRIG_EN
        check("trig_once", trig_cnt - t0, 1);
`endif

        // Slew 30 snaps on the fourth tick.
        jump(0);
        slew   = 8'd30;
        sig_in = 12'sd100;
        ramp_exp(0, 100, 30);
        drain("ramp30", 60);

        // Reversal at 50.
        jump(0);
`ifdef SEQ_GLIDE_TRIG_EN
        t0 = trig_cnt;
`endif
        slew   = 8'd10;
        sig_in = 12'sd100;
        ramp_exp(0, 50, 10);
        sb[sb.size() - 1].busy = 1'b1;
        wait_val(50, 60);
        sig_in = 12'sd20;
        push(40, RateDiv, 1'b1);
        push(30, RateDiv, 1'b1);
        push(20, RateDiv, 1'b0);
        drain("reverse", 60);
`ifdef SEQ_GLIDE_TRIG_EN
        check("trig_twice", trig_cnt - t0, 2);
`endif

        // Full scale both ways with slew 255.
        jump(-2048);
        slew   = 8'd255;
        sig_in = 12'sd2047;
        ramp_exp(-2048, 2047, 255);
        check("full_up_len", sb.size(), 17);
        drain("full_up", 200);
        sig_in = -12'sd2048;
        ramp_exp(2047, -2048, 255);
        drain("full_down", 200);

        // Bypass: value appears two edges after the change.
        jump(0);
        sig_in = -12'sd500;
        push(-500, 0, 1'b0);
        tick_edge();
        check("bypass_e1_val", int'(sig_out), 0);
        check("bypass_e1_busy", int'(busy), 1);
        tick_edge();
        check("bypass_e2_val", int'(sig_out), -500);
        check("bypass_e2_busy", int'(busy), 0);
        drain("bypass", 10);

        // Reset mid-ramp at 60, then restart from 0.
        jump(0);
`ifdef SEQ_GLIDE_TRIG_EN
        t0 = trig_cnt;
`endif
        slew   = 8'd10;
        sig_in = 12'sd100;
        ramp_exp(0, 60, 10);
        sb[sb.size() - 1].busy = 1'b1;
        wait_val(60, 60);
        push(0, 0, 1'b0);
        rst = 1'b1;
        tick_edge();
        check("midrst_sigout", int'(sig_out), 0);
        check("midrst_busy", int'(busy), 0);
`ifdef SEQ_GLIDE_TRIG_EN
        check("midrst_trig", int'(trig), 0);
`endif
        rst = 1'b0;
        ramp_exp(0, 100, 10);
        sb[sb.size() - 10].gap = RateDiv;
        drain("restart", 100);
`ifdef SEQ_GLIDE_TRIG_EN
        check("trig_restart", trig_cnt - t0, 2);
`endif

        repeat (2) tick_edge();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
